// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_e       : controller state encoding (IDLE, BUSY, DONE)
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder_cell.sv
// Full adder built from two half adders plus an OR of their carries.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell processes one bit per clock, LSB first.
// Optional subtraction mode is enabled by defining SERIAL_ADDER_SUB_EN.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : operands a/b valid          in_ready  : operands can be accepted
//   a, b      : WIDTH-bit operands          sub       : 1 = compute a - b (macro only)
//   out_valid : sum/cout valid              out_ready : consumer takes the result
//   sum       : WIDTH-bit result            cout      : carry out of the MSB (NOT borrow in sub)
//   busy      : high while bits are being processed
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;

    logic             fa_s;
    logic             fa_c;

    // Load values: subtraction is a + ~b + 1, with the +1 entering as the initial carry.
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    full_adder_cell u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy    = 1'b1;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                carry_d          = fa_c;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    // Carry FF is untouched in DONE, so it holds the final carry stably.
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8).
// Subtraction vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns number of edges waited.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 64) begin
            tick();
            cycles++;
        end
    endtask

    // Present operands for one accepting edge, then wait for and check the result.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, lat, W);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        tick();
    endtask

    initial begin
        int lat;
        int acc_idx;
        int out_idx;
        int last_out;
        logic acc;
        logic [W-1:0] bb_a [3];
        logic [W-1:0] bb_b [3];
        logic [W-1:0] bb_s [3];
        logic         bb_c [3];
        int out_t [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();

        // Reset with in_valid high: nothing accepted.
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        tick();
        check("rst_win_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_win_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;

        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);

        // Basic additions.
        a        = 8'h3C;
        b        = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_in_busy", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check("add1_latency", lat, W);
        check("add1_sum", {24'd0, sum}, 32'h96);
        check("add1_cout", {31'd0, cout}, 32'd0);
        check("add1_busy_done", {31'd0, busy}, 32'd0);
        tick();
        check("add1_back_idle", {31'd0, in_ready}, 32'd1);

        run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0);

        // Backpressure in DONE while new operands are offered.
        out_ready = 1'b0;
        a         = 8'h11;
        b         = 8'h22;
        in_valid  = 1'b1;
        tick();
        a = 8'hAA;
        b = 8'hBB;
        wait_valid(lat);
        check("bp_latency", lat, W);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {24'd0, sum}, 32'h33);
            check("bp_cout", {31'd0, cout}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        a = 8'h05;
        b = 8'h07;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_next_latency", lat, W);
        check("bp_next_sum", {24'd0, sum}, 32'h0C);
        check("bp_next_cout", {31'd0, cout}, 32'd0);
        tick();

        // Reset during the 3rd BUSY cycle, carry set at that point.
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        run_op("midrst_add", 8'h01, 8'h01, 8'h02, 1'b0);

        // Back-to-back with in_valid held high.
        bb_a[0] = 8'h01; bb_b[0] = 8'h02; bb_s[0] = 8'h03; bb_c[0] = 1'b0;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_s[1] = 8'h00; bb_c[1] = 1'b1;
        bb_a[2] = 8'h7F; bb_b[2] = 8'h01; bb_s[2] = 8'h80; bb_c[2] = 1'b0;
        acc_idx  = 0;
        out_idx  = 0;
        a        = bb_a[0];
        b        = bb_b[0];
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 60 && out_idx < 3; cyc++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                acc_idx++;
                if (acc_idx < 3) begin
                    a = bb_a[acc_idx];
                    b = bb_b[acc_idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b_sum", {24'd0, sum}, {24'd0, bb_s[out_idx]});
                check("b2b_cout", {31'd0, cout}, {31'd0, bb_c[out_idx]});
                out_t[out_idx] = cyc;
                out_idx++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", out_idx, 3);
        if (out_idx == 3) begin
            last_out = out_t[1] - out_t[0];
            check("b2b_spacing01", last_out, W + 2);
            last_out = out_t[2] - out_t[1];
            check("b2b_spacing12", last_out, W + 2);
        end
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b1);
        run_op("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b0);
        sub = 1'b0;
        run_op("sub_off_add", 8'h10, 8'h01, 8'h11, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder that produces a WIDTH-bit sum plus carry-out.
- Processes one bit per clock, LSB first, through a single full-adder cell built from two HalfAdder instances.
- Sits as the sequential wrapper directly around the HalfAdder datapath.
- Upstream producer and downstream consumer connect through valid/ready handshakes, so the block trades area for latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  addend
- b  in  WIDTH  addend
- out_valid  out  1  sum/cout valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB
- busy  out  1  high while bits are being processed

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, carry FF=0.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge T: latch a and b into right-shift registers, clear carry FF, clear counter, go to BUSY.
- BUSY, each cycle:
  - Full-adder bit = HalfAdder(a_sr[0], b_sr[0]) followed by HalfAdder(s1, carry). Carry next = c1 | c2.
  - The sum bit shifts into the sum register at the MSB end, shifting right.
  - a_sr and b_sr shift right; counter increments.
  - When counter == WIDTH-1 the last bit is processed; next state is DONE.
- DONE:
  - out_valid=1.
  - sum holds the full result; cout = final carry.
  - Both stay stable until out_ready is sampled high; then go to IDLE.
- Latency: out_valid rises exactly WIDTH cycles after the acceptance edge T. Throughput is one result per WIDTH+2 cycles minimum.
- busy=1 only in BUSY. in_ready=0 in BUSY and DONE; in_valid is ignored there and operands are not captured.
- sum/cout are don't-care while out_valid=0, but the implementation must not glitch them in DONE.
- Counter width is $clog2(WIDTH+1). WIDTH=1 completes in one BUSY cycle.
- Reset in any state: returns to IDLE on the next edge. Any in-flight result is discarded and out_valid drops in the following cycle.
- Simultaneous rst with in_valid: rst wins; nothing is accepted.
- out_valid & out_ready handshake in DONE: next state is IDLE. New operands can be accepted on the following edge (no same-cycle bypass).

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), captured with a/b at acceptance.
  - If sub=1: b is inverted at load and the carry FF initialises to 1, so sum = a - b mod 2^WIDTH and cout = NOT borrow.
  - sub=0 behaves as plain addition.
- When undefined: no sub port; the carry FF always initialises to 0.

Decomposition:
- Package serial_adder_pkg: state enum typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default width constant.
- One natural sub-module, full_adder_cell: two HalfAdder instances plus an OR on the carries.
- serial_adder instantiates one full_adder_cell. FSM, counter and shift registers stay in the top.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=0, b=0 -> sum=0, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout/out_valid stable, in_ready=0, new operands not captured; after out_ready=1 the next accept takes the then-present operands.
- Reset mid-BUSY: assert rst at the 3rd BUSY cycle -> next cycle state IDLE, in_ready=1, out_valid=0, busy=0; a subsequent 8'h01+8'h01 gives 8'h02, with no stale carry.
- Back-to-back: in_valid held high, out_ready=1, three operand pairs -> three results in order, spaced WIDTH+2 cycles apart.
- With SERIAL_ADDER_SUB_EN:
  - 8'h10-8'h01 -> sum=8'h0F, cout=1.
  - 8'h00-8'h01 -> sum=8'hFF, cout=0.
  - WIDTH=1 build: 1'b1+1'b1 -> sum=0, cout=1 after 1 cycle.
